// File: rtl/issue_sequencer.sv
// issue_sequencer: issue-stage scoreboard sequencer plus round-robin clear arbiter.
// Optional build macro ISSUE_STALL_COUNT_EN adds a saturating stall_count output.
module issue_sequencer #(
    parameter int unsigned NUM_WB  = 2,
    parameter int unsigned STALL_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic [4:0]            id_rd,
    input  logic                  id_uses_rt,
    input  logic                  id_writes,
    input  logic [1:0]            id_stage,
    output logic                  iss_valid,
    output logic [4:0]            iss_rd,
    output logic [4:0]            sb_addr,
    input  logic [7:0]            sb_data,
    output logic [4:0]            sb_writeaddr,
    output logic [1:0]            sb_stage,
    output logic                  sb_enablewrite,
    output logic [4:0]            sb_clearaddr,
    output logic                  sb_enableclear,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [5*NUM_WB-1:0]   wb_addr,
    output logic [NUM_WB-1:0]     wb_ready
`ifdef ISSUE_STALL_COUNT_EN
    ,
    output logic [STALL_W-1:0]    stall_count
`endif
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned PTR_W = (NUM_WB > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, CHK_RS, CHK_RT, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [REG_W-1:0]   rs_q, rt_q, rd_q;
    logic               uses_rt_q, writes_q;
    logic [1:0]         stage_q;
    logic               stalled;

    logic [PTR_W-1:0]   ptr_q, grant_idx, cand;
    logic               grant_found, grant;
    logic [REG_W-1:0]   wb_addr_a [NUM_WB];

    // State register and instruction latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            uses_rt_q <= 1'b0;
            writes_q  <= 1'b0;
            stage_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && id_valid) begin
                rs_q      <= id_rs;
                rt_q      <= id_rt;
                rd_q      <= id_rd;
                uses_rt_q <= id_uses_rt;
                writes_q  <= id_writes;
                stage_q   <= id_stage;
            end
        end
    end

    // Next state and scoreboard read/mark strobes; register 0 never stalls
    always_comb begin
        state_d        = state_q;
        id_ready       = 1'b0;
        iss_valid      = 1'b0;
        iss_rd         = '0;
        sb_addr        = '0;
        sb_enablewrite = 1'b0;
        sb_writeaddr   = '0;
        sb_stage       = '0;
        stalled        = 1'b0;
        case (state_q)
            IDLE: begin
                id_ready = 1'b1;
                if (id_valid) state_d = CHK_RS;
            end
            CHK_RS: begin
                sb_addr = rs_q;
                if (rs_q == '0 || !sb_data[0]) state_d = uses_rt_q ? CHK_RT : ISSUE;
                else                           stalled = 1'b1;
            end
            CHK_RT: begin
                sb_addr = rt_q;
                if (rt_q == '0 || !sb_data[0]) state_d = ISSUE;
                else                           stalled = 1'b1;
            end
            ISSUE: begin
                iss_valid = 1'b1;
                iss_rd    = rd_q;
                if (writes_q && rd_q != '0) begin
                    sb_enablewrite = 1'b1;
                    sb_writeaddr   = rd_q;
                    sb_stage       = stage_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_addr
        assign wb_addr_a[k] = wb_addr[REG_W*k +: REG_W];
    end

    // Round-robin search starting at the pointer, wrapping around
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_WB);
            if (!grant_found && wb_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A same-cycle mark of the same register wins over the clear
    assign grant = grant_found && !reset &&
                   !(sb_enablewrite && wb_addr_a[grant_idx] == sb_writeaddr);
    assign sb_enableclear = grant;
    assign sb_clearaddr   = grant ? wb_addr_a[grant_idx] : '0;
    assign wb_ready       = grant ? (NUM_WB'(1'b1) << grant_idx) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= (32'(grant_idx) == NUM_WB - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end

`ifdef ISSUE_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_q;
    logic               unused_bits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                        stall_q <= '0;
        else if (stalled && stall_q != '1) stall_q <= stall_q + STALL_W'(1);
    end

    assign stall_count = stall_q;
    assign unused_bits = ^sb_data[7:1];
`else
    logic               unused_bits;
    logic [STALL_W-1:0] unused_stall_w;

    assign unused_bits    = ^{sb_data[7:1], stalled};
    assign unused_stall_w = '0;
`endif

endmodule

// File: tb/tb_issue_sequencer.sv
// Self-checking bench for issue_sequencer: directed scenarios plus randomized
// issue/arbitration traffic against a cycle-arithmetic reference model.
module tb_issue_sequencer;

    localparam int unsigned NUM_WB  = 2;
    localparam int unsigned STALL_W = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               id_valid, id_ready;
    logic [4:0]         id_rs, id_rt, id_rd;
    logic               id_uses_rt, id_writes;
    logic [1:0]         id_stage;
    logic               iss_valid;
    logic [4:0]         iss_rd;
    logic [4:0]         sb_addr;
    logic [7:0]         sb_data;
    logic [4:0]         sb_writeaddr;
    logic [1:0]         sb_stage;
    logic               sb_enablewrite;
    logic [4:0]         sb_clearaddr;
    logic               sb_enableclear;
    logic [NUM_WB-1:0]  wb_valid;
    logic [5*NUM_WB-1:0] wb_addr;
    logic [NUM_WB-1:0]  wb_ready;
`ifdef ISSUE_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_count;
`endif

    issue_sequencer #(.NUM_WB(NUM_WB), .STALL_W(STALL_W)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_writes(id_writes), .id_stage(id_stage),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .sb_addr(sb_addr), .sb_data(sb_data),
        .sb_writeaddr(sb_writeaddr), .sb_stage(sb_stage), .sb_enablewrite(sb_enablewrite),
        .sb_clearaddr(sb_clearaddr), .sb_enableclear(sb_enableclear),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready)
`ifdef ISSUE_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stalls = 0;

    // Scoreboard environment: either a live pending table fed by the DUT's
    // strobes, or a schedule where register r is pending while cyc < rel[r].
    logic        sched;
    int          rel [32];
    logic [31:0] sb_pend;
    logic        sb_flush, tb_set;
    logic [4:0]  tb_set_addr;
    logic        pend;

    always_comb begin
        pend    = sched ? (cyc < rel[sb_addr]) : sb_pend[sb_addr];
        sb_data = {5'd0, 2'd1, pend};
    end

    always @(posedge clock) begin
        if (sb_flush) begin
            sb_pend <= '0;
        end else begin
            if (tb_set)         sb_pend[tb_set_addr]  <= 1'b1;
            if (sb_enablewrite) sb_pend[sb_writeaddr] <= 1'b1;
            if (sb_enableclear) sb_pend[sb_clearaddr] <= 1'b0;
        end
    end

    // Observations recorded by run_instr
    int         t_acc, iss_cyc;
    logic       acc_rdy, we_obs;
    logic [4:0] rd_obs, wa_obs;
    logic [1:0] st_obs;

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; id_valid = 1'b0; wb_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        exp_stalls = 0;
    endtask

    task automatic flush_sb();
        @(negedge clock); sb_flush = 1'b1;
        @(negedge clock); sb_flush = 1'b0;
    endtask

    task automatic set_pending(input logic [4:0] r);
        @(negedge clock); tb_set = 1'b1; tb_set_addr = r;
        @(negedge clock); tb_set = 1'b0;
    endtask

    // Present one instruction and record when and how it issues (no checking)
    task automatic run_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic urt, input logic wr, input logic [1:0] st);
        @(negedge clock);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rt = urt; id_writes = wr; id_stage = st;
        #1;
        acc_rdy = id_ready;
        t_acc   = cyc;
        iss_cyc = -1;
        @(negedge clock);
        id_valid = 1'b0;
        for (int k = 0; k < 40 && iss_cyc < 0; k++) begin
            #1;
            if (iss_valid === 1'b1) begin
                iss_cyc = cyc; rd_obs = iss_rd; we_obs = sb_enablewrite;
                wa_obs = sb_writeaddr; st_obs = sb_stage;
            end
            if (iss_cyc < 0) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; id_valid = 1'b0; wb_valid = '0; wb_addr = '0;
        #1;
        n_checks++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready: got %0b expected 1", id_ready); else n_pass++;
        n_checks++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid); else n_pass++;
        n_checks++; if (sb_enablewrite !== 1'b0) $display("FAIL reset_enablewrite: got %0b expected 0", sb_enablewrite); else n_pass++;
        n_checks++; if (sb_addr !== 5'd0) $display("FAIL reset_sb_addr: got %0d expected 0", sb_addr); else n_pass++;
        wb_valid = 2'b11;
        #1;
        n_checks++; if (sb_enableclear !== 1'b0 || wb_ready !== 2'b00)
            $display("FAIL reset_clear_grant: enableclear=%0b wb_ready=%b expected 0/00", sb_enableclear, wb_ready); else n_pass++;
`ifdef ISSUE_STALL_COUNT_EN
        n_checks++; if (stall_count !== '0) $display("FAIL reset_stall_count: got %0d expected 0", stall_count); else n_pass++;
`endif
        @(negedge clock);
        reset = 1'b0; wb_valid = '0; exp_stalls = 0;
    endtask

    task automatic test_basic_issue();
        sched = 1'b0;
        flush_sb();
        run_instr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 2'd2);
        n_checks++; if (acc_rdy !== 1'b1) $display("FAIL basic_accept: id_ready=%0b expected 1", acc_rdy); else n_pass++;
        n_checks++; if (iss_cyc != t_acc + 3) $display("FAIL basic_latency: issue at %0d expected %0d", iss_cyc, t_acc + 3); else n_pass++;
        n_checks++; if (rd_obs !== 5'd5) $display("FAIL basic_iss_rd: got %0d expected 5", rd_obs); else n_pass++;
        n_checks++; if (we_obs !== 1'b1 || wa_obs !== 5'd5 || st_obs !== 2'd2)
            $display("FAIL basic_mark: we=%0b addr=%0d stage=%0d expected 1/5/2", we_obs, wa_obs, st_obs); else n_pass++;
    endtask

    task automatic test_stall_clear();
        int g;
        sched = 1'b0;
        flush_sb();
        set_pending(5'd3);
        @(negedge clock);
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd0; id_rd = 5'd0;
        id_uses_rt = 1'b0; id_writes = 1'b0; id_stage = 2'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); id_valid = 1'b0; #1;
            n_checks++; if (iss_valid !== 1'b0 || sb_addr !== 5'd3)
                $display("FAIL stall_hold: iss_valid=%0b sb_addr=%0d expected 0/3", iss_valid, sb_addr); else n_pass++;
        end
        @(negedge clock);
        wb_valid = 2'b01; wb_addr = {5'd0, 5'd3};
        #1;
        g = cyc;
        n_checks++; if (wb_ready !== 2'b01 || sb_clearaddr !== 5'd3 || sb_enableclear !== 1'b1)
            $display("FAIL stall_grant: wb_ready=%b clearaddr=%0d expected 01/3", wb_ready, sb_clearaddr); else n_pass++;
        exp_stalls += 4;
        @(negedge clock); wb_valid = '0; #1;
        n_checks++; if (iss_valid !== 1'b0) $display("FAIL stall_early_issue: iss_valid=%0b expected 0", iss_valid); else n_pass++;
        @(negedge clock); #1;
        n_checks++; if (iss_valid !== 1'b1 || cyc != g + 2)
            $display("FAIL stall_release: iss_valid=%0b at cycle %0d expected 1 at %0d", iss_valid, cyc, g + 2); else n_pass++;
`ifdef ISSUE_STALL_COUNT_EN
        n_checks++; if (stall_count !== STALL_W'(exp_stalls))
            $display("FAIL stall_count: got %0d expected %0d", stall_count, exp_stalls); else n_pass++;
`endif
    endtask

    task automatic test_alternate();
        int e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            wb_valid = 2'b11; wb_addr = {5'd8, 5'd7};
            #1;
            e = k % 2;
            n_checks++; if (wb_ready !== 2'(1 << e) || sb_clearaddr !== (e == 1 ? 5'd8 : 5'd7))
                $display("FAIL rr_alternate%0d: wb_ready=%b clearaddr=%0d expected %b/%0d",
                         k, wb_ready, sb_clearaddr, 2'(1 << e), (e == 1 ? 8 : 7)); else n_pass++;
        end
        @(negedge clock); wb_valid = '0;
    endtask

    task automatic test_collision();
        sched = 1'b0;
        @(negedge clock);
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd9;
        id_uses_rt = 1'b0; id_writes = 1'b1; id_stage = 2'd1;
        @(negedge clock); id_valid = 1'b0;
        @(negedge clock);
        wb_valid = 2'b10; wb_addr = {5'd9, 5'd0};
        #1;
        n_checks++; if (iss_valid !== 1'b1 || sb_enablewrite !== 1'b1 || sb_writeaddr !== 5'd9)
            $display("FAIL collide_issue: iss=%0b we=%0b wa=%0d expected 1/1/9", iss_valid, sb_enablewrite, sb_writeaddr); else n_pass++;
        n_checks++; if (sb_enableclear !== 1'b0 || wb_ready !== 2'b00)
            $display("FAIL collide_suppress: enableclear=%0b wb_ready=%b expected 0/00", sb_enableclear, wb_ready); else n_pass++;
        @(negedge clock); #1;
        n_checks++; if (wb_ready !== 2'b10 || sb_clearaddr !== 5'd9)
            $display("FAIL collide_retry: wb_ready=%b clearaddr=%0d expected 10/9", wb_ready, sb_clearaddr); else n_pass++;
        wb_valid = '0;
    endtask

    task automatic test_zero_regs();
        sched = 1'b1;
        rel[0] = cyc + 1000;
        run_instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd3);
        n_checks++; if (iss_cyc != t_acc + 3) $display("FAIL zero_latency: issue at %0d expected %0d", iss_cyc, t_acc + 3); else n_pass++;
        n_checks++; if (we_obs !== 1'b0) $display("FAIL zero_no_mark: we=%0b expected 0", we_obs); else n_pass++;
        rel[0] = 0;
        sched = 1'b0;
    endtask

    task automatic test_reset_midop();
        sched = 1'b0;
        flush_sb();
        set_pending(5'd4);
        @(negedge clock);
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd6;
        id_uses_rt = 1'b1; id_writes = 1'b1; id_stage = 2'd1;
        @(negedge clock); id_valid = 1'b0;
        @(negedge clock); #1;
        n_checks++; if (sb_addr !== 5'd4 || iss_valid !== 1'b0)
            $display("FAIL midop_in_chk_rt: sb_addr=%0d iss=%0b expected 4/0", sb_addr, iss_valid); else n_pass++;
        @(negedge clock);
        reset = 1'b1; wb_valid = 2'b01; wb_addr = {5'd0, 5'd2};
        #1;
        n_checks++; if (id_ready !== 1'b1 || iss_valid !== 1'b0 || sb_enablewrite !== 1'b0 || sb_enableclear !== 1'b0)
            $display("FAIL midop_reset: ready=%0b iss=%0b we=%0b ec=%0b expected 1/0/0/0",
                     id_ready, iss_valid, sb_enablewrite, sb_enableclear); else n_pass++;
        @(negedge clock);
        reset = 1'b0; wb_valid = '0; exp_stalls = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock); #1;
            n_checks++; if (iss_valid !== 1'b0 || sb_enablewrite !== 1'b0 || id_ready !== 1'b1)
                $display("FAIL midop_quiet%0d: iss=%0b we=%0b ready=%0b expected 0/0/1",
                         k, iss_valid, sb_enablewrite, id_ready); else n_pass++;
        end
`ifdef ISSUE_STALL_COUNT_EN
        n_checks++; if (stall_count !== '0) $display("FAIL midop_stall_count: got %0d expected 0", stall_count); else n_pass++;
`endif
    endtask

    task automatic test_random_issue();
        logic [4:0] rs, rt, rd;
        logic       urt, wr, exp_we;
        logic [1:0] st;
        int base, c1, c2, exp_iss;
        do_reset();
        sched = 1'b1;
        for (int n = 0; n < 25; n++) begin
            base = cyc + 1;
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 31));
            urt = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            st  = 2'($urandom_range(0, 3));
            rel[rs] = base + int'($urandom_range(0, 6));
            rel[rt] = base + int'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) rel[0] = base + 50;
            run_instr(rs, rt, rd, urt, wr, st);
            // Source passes in the first check cycle at or after its release
            c1 = (rs == 0) ? t_acc + 1 : ((rel[rs] > t_acc + 1) ? rel[rs] : t_acc + 1);
            if (urt) begin
                c2 = (rt == 0) ? c1 + 1 : ((rel[rt] > c1 + 1) ? rel[rt] : c1 + 1);
                exp_iss = c2 + 1;
            end else begin
                exp_iss = c1 + 1;
            end
            exp_stalls += exp_iss - t_acc - (urt ? 3 : 2);
            exp_we = wr && (rd != 5'd0);
            n_checks++; if (acc_rdy !== 1'b1) $display("FAIL rnd_accept%0d: id_ready=%0b expected 1", n, acc_rdy); else n_pass++;
            n_checks++; if (iss_cyc != exp_iss) $display("FAIL rnd_issue_cycle%0d: got %0d expected %0d", n, iss_cyc, exp_iss); else n_pass++;
            n_checks++; if (rd_obs !== rd) $display("FAIL rnd_iss_rd%0d: got %0d expected %0d", n, rd_obs, rd); else n_pass++;
            n_checks++; if (we_obs !== exp_we) $display("FAIL rnd_we%0d: got %0b expected %0b", n, we_obs, exp_we); else n_pass++;
            if (exp_we) begin
                n_checks++; if (wa_obs !== rd || st_obs !== st)
                    $display("FAIL rnd_mark%0d: addr=%0d stage=%0d expected %0d/%0d", n, wa_obs, st_obs, rd, st); else n_pass++;
            end
`ifdef ISSUE_STALL_COUNT_EN
            n_checks++; if (stall_count !== STALL_W'(exp_stalls))
                $display("FAIL rnd_stall_count%0d: got %0d expected %0d", n, stall_count, exp_stalls); else n_pass++;
`endif
        end
        sched = 1'b0;
    endtask

    task automatic test_random_arb();
        int ptr, idx, c;
        logic found;
        logic [4:0] exp_addr;
        do_reset();
        ptr = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            wb_valid = 2'($urandom);
            wb_addr  = 10'($urandom);
            #1;
            found = 1'b0; idx = 0;
            for (int i = 0; i < int'(NUM_WB); i++) begin
                c = (ptr + i) % int'(NUM_WB);
                if (!found && wb_valid[c]) begin found = 1'b1; idx = c; end
            end
            exp_addr = (idx == 1) ? wb_addr[9:5] : wb_addr[4:0];
            n_checks++; if (wb_ready !== (found ? 2'(1 << idx) : 2'b00) || sb_enableclear !== found)
                $display("FAIL rnd_arb%0d: wb_ready=%b ec=%0b expected %b/%0b",
                         n, wb_ready, sb_enableclear, (found ? 2'(1 << idx) : 2'b00), found); else n_pass++;
            if (found) begin
                n_checks++; if (sb_clearaddr !== exp_addr)
                    $display("FAIL rnd_arb_addr%0d: got %0d expected %0d", n, sb_clearaddr, exp_addr); else n_pass++;
                ptr = (idx + 1) % int'(NUM_WB);
            end
        end
        @(negedge clock); wb_valid = '0;
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_uses_rt = 1'b0; id_writes = 1'b0; id_stage = '0;
        wb_valid = '0; wb_addr = '0;
        sched = 1'b0; sb_flush = 1'b1; tb_set = 1'b0; tb_set_addr = '0;
        for (int r = 0; r < 32; r++) rel[r] = 0;
        test_reset();
        sb_flush = 1'b0;
        test_basic_issue();
        test_stall_clear();
        test_alternate();
        test_collision();
        test_zero_regs();
        test_reset_midop();
        test_random_issue();
        test_random_arb();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_sequencer.md
# issue_sequencer

Issue-stage controller that sequences the register scoreboard. It accepts one decoded instruction at a time and checks its source registers against the scoreboard's single read port, stalling while either source is pending. On issue it marks the destination pending. It also arbitrates the scoreboard's single clear port among the writeback units, round-robin. It sits between decode and the execution pipeline, in front of the Scoreboard block.

## Interface
- NUM_WB, 2: number of writeback requesters; legal range 2..4.
- STALL_W, 16: stall counter width; used only with the macro described under Configuration.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  sequencer accepts the instruction this cycle.
- id_rs, id_rt, id_rd  in  5 each  source and destination register numbers.
- id_uses_rt  in  1  instruction reads rt.
- id_writes  in  1  instruction writes rd.
- id_stage  in  2  stage that produces rd; forwarded to the scoreboard.
- iss_valid  out  1  one-cycle issue pulse.
- iss_rd  out  5  destination of the issued instruction.
- sb_addr  out  5  scoreboard read address, connected to ass_addr.
- sb_data  in  8  scoreboard read data, combinational. Bit 0 is the pending flag; bits [2:1] are the producing stage.
- sb_writeaddr  out  5  destination to mark pending.
- sb_stage  out  2  producing stage written with the pending mark.
- sb_enablewrite  out  1  mark-pending strobe.
- sb_clearaddr  out  5  register to clear.
- sb_enableclear  out  1  clear strobe.
- wb_valid  in  NUM_WB  writeback unit has a completed result.
- wb_addr  in  5*NUM_WB  destination of each writeback unit; unit k occupies [5k+4:5k].
- wb_ready  out  NUM_WB  one-hot clear grant.
- stall_count  out  STALL_W  present only with ISSUE_STALL_COUNT_EN.

## Operation
- FSM states: IDLE, CHK_RS, CHK_RT, ISSUE. Reset state is IDLE.
- IDLE: id_ready=1. When id_valid=1, latch rs, rt, rd, uses_rt, writes and stage, then go to CHK_RS.
- CHK_RS: sb_addr=rs.
  - If rs==0 or sb_data[0]==0: go to CHK_RT when uses_rt=1, otherwise go to ISSUE.
  - Otherwise stay in CHK_RS (stall).
- CHK_RT: sb_addr=rt. Same rule as CHK_RS; on pass, go to ISSUE.
- ISSUE: iss_valid=1 and iss_rd=rd.
  - If writes=1 and rd!=0: sb_enablewrite=1, sb_writeaddr=rd, sb_stage=stage.
  - Next state is IDLE.
- sb_addr is 0 in IDLE and ISSUE.
- Clear arbiter runs every cycle, independent of the FSM.
  - A round-robin pointer selects the first requester with wb_valid set, searching from the pointer upward with wrap-around.
  - Grant: wb_ready[k]=1, sb_enableclear=1, sb_clearaddr=wb_addr[k].
  - After a grant, the pointer moves to k+1 mod NUM_WB. With no grant, the pointer is unchanged.
- Write/clear collision: if sb_enablewrite=1 and the selected clear address equals sb_writeaddr, suppress the grant for that cycle. The unit stays valid, the pointer is unchanged, and the newer write wins.
- A clear to register 0 is granted normally; the scoreboard ignores it.
- Only one instruction is in flight: no new accept until the FSM returns to IDLE.

## Timing
- Reset values:
  - state IDLE, pointer 0.
  - Latched fields 0.
  - iss_valid, sb_enablewrite, sb_enableclear and wb_ready all 0.
  - stall_count 0.
- Minimum accept-to-issue latency: IDLE → CHK_RS → (CHK_RT) → ISSUE, so iss_valid arrives 2 cycles after accept without rt and 3 cycles with rt. Each stalled cycle adds 1.
- Back-to-back throughput: one instruction per 3 cycles (no rt) or per 4 cycles (with rt).
- All scoreboard strobes and wb_ready are combinational from registered state plus current wb_valid and sb_data.
- A clear granted in cycle N is visible on sb_data in cycle N+1. A stalled source therefore passes at the earliest one cycle after its clear.
- Reset asserted mid-operation: the FSM returns to IDLE at once, the latched instruction is discarded, no iss_valid is produced, and no scoreboard strobe is driven.

## Configuration
- ISSUE_STALL_COUNT_EN defined:
  - stall_count increments by 1 in every CHK_RS or CHK_RT cycle that stalls.
  - It saturates at all-ones and clears only on reset.
- Macro not defined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset, then id_valid with rs=3, rt=4, uses_rt=1, rd=5, writes=1, stage=2, scoreboard all clear → iss_valid at cycle 3 after accept; sb_enablewrite=1 with writeaddr=5, stage=2.
- Scoreboard has r3 pending; issue rs=3 → held in CHK_RS. Drive wb_valid[0] with addr 3 → clear granted; iss_valid 2 cycles after the grant; stall_count equals the number of stalled cycles.
- wb_valid=2'b11 held for 4 cycles with addrs 7 and 8 → grants alternate 0,1,0,1 and sb_clearaddr alternates 7,8,7,8.
- ISSUE with rd=9 while wb_valid[1] carries addr 9 → no clear in that cycle; the clear is granted the following cycle.
- rs=0, rt=0 with the scoreboard reporting pending for 0 → no stall; issue proceeds.
- Assert reset while in CHK_RT → next cycle state is IDLE, id_ready=1, and no iss_valid or sb_enablewrite is ever driven for that instruction.
